// File: rtl/if_stage.sv
// Instruction fetch stage: drives one outstanding fetch to the memory
// controller, registers the fetched instruction and its PCs for IF/ID, and
// predicts the next PC.
// Optional feature macro: BTB_EN adds a direct-mapped branch target buffer.
// Without it the predicted PC is always pc+4 and the btb_* inputs are ignored.

`ifndef AddrLen
`define AddrLen 32
`endif
`ifndef InstLen
`define InstLen 32
`endif
`ifndef PipelineDepth
`define PipelineDepth 5
`endif
`ifndef FlushInst
`define FlushInst 32'h0000_0013
`endif

module if_stage #(
  parameter int BTB_ENTRIES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [`PipelineDepth-1:0] stall,
  input  logic                      flush,
  input  logic [`AddrLen-1:0]       flush_target,
  output logic                      mem_req,
  output logic [`AddrLen-1:0]       mem_addr,
  input  logic                      mem_ready,
  input  logic [`InstLen-1:0]       mem_rdata,
  output logic                      stall_req,
  output logic [`AddrLen-1:0]       if_pc,
  output logic [`AddrLen-1:0]       if_npc,
  output logic [`AddrLen-1:0]       if_prediction,
  output logic [`InstLen-1:0]       if_inst,
  input  logic                      btb_we,
  input  logic [`AddrLen-1:0]       btb_wpc,
  input  logic [`AddrLen-1:0]       btb_wtarget
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE, DISCARD} state_e;

  state_e state_q, state_d;
  logic [`AddrLen-1:0] pc_q, pc_d;
  logic [`AddrLen-1:0] mem_addr_q, mem_addr_d;
  logic [`AddrLen-1:0] disc_target_q, disc_target_d;
  logic [`AddrLen-1:0] if_pc_q, if_pc_d;
  logic [`AddrLen-1:0] if_npc_q, if_npc_d;
  logic [`AddrLen-1:0] if_pred_q, if_pred_d;
  logic [`InstLen-1:0] if_inst_q, if_inst_d;
  logic [`AddrLen-1:0] pc_plus4;
  logic [`AddrLen-1:0] pred_pc;

  assign pc_plus4 = pc_q + `AddrLen'(4);

`ifdef BTB_EN
  localparam int IdxW = $clog2(BTB_ENTRIES);
  localparam int TagW = `AddrLen - IdxW - 2;

  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TagW-1:0]        btb_tag_q    [BTB_ENTRIES];
  logic [`AddrLen-1:0]    btb_target_q [BTB_ENTRIES];
  logic [IdxW-1:0]        rd_idx;
  logic [IdxW-1:0]        wr_idx;

  assign rd_idx = pc_q[IdxW+1:2];
  assign wr_idx = btb_wpc[IdxW+1:2];

  // Valid bits are the only BTB state that must be cleared by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_valid_q <= '0;
    end else if (btb_we) begin
      btb_valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/target storage; a same-cycle lookup sees the pre-write contents
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag_q[wr_idx]    <= btb_wpc[`AddrLen-1:IdxW+2];
      btb_target_q[wr_idx] <= btb_wtarget;
    end
  end

  assign pred_pc = (btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == pc_q[`AddrLen-1:IdxW+2]))
                   ? btb_target_q[rd_idx] : pc_plus4;

  wire unused_btb = ^{btb_wpc[1:0], stall[`PipelineDepth-1:1]};
`else
  assign pred_pc = pc_plus4;

  wire unused_btb = ^{btb_we, btb_wpc, btb_wtarget, stall[`PipelineDepth-1:1], (BTB_ENTRIES == 0)};
`endif

  // Memory handshake is outstanding exactly while waiting or discarding
  assign mem_req       = (state_q == WAIT) || (state_q == DISCARD);
  assign stall_req     = mem_req;
  assign mem_addr      = mem_addr_q;
  assign if_pc         = if_pc_q;
  assign if_npc        = if_npc_q;
  assign if_prediction = if_pred_q;
  assign if_inst       = if_inst_q;

  // Next-state logic: fetch sequencing, redirects and the discard of stale data
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    disc_target_d = disc_target_q;
    if_pc_d       = if_pc_q;
    if_npc_d      = if_npc_q;
    if_pred_d     = if_pred_q;
    if_inst_d     = if_inst_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (flush) begin
          pc_d      = flush_target;
          if_inst_d = `FlushInst;
          if_pc_d   = '0;
          if_npc_d  = '0;
          if_pred_d = '0;
          state_d   = IDLE;
        end else if (!stall[0]) begin
          if (state_q == IDLE) begin
            mem_addr_d = pc_q;
            state_d    = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT: begin
        if (mem_ready && flush) begin
          pc_d      = flush_target;
          if_inst_d = `FlushInst;
          if_pc_d   = '0;
          if_npc_d  = '0;
          if_pred_d = '0;
          state_d   = IDLE;
        end else if (mem_ready) begin
          if_inst_d = mem_rdata;
          if_pc_d   = pc_q;
          if_npc_d  = pc_plus4;
          if_pred_d = pred_pc;
          pc_d      = pred_pc;
          state_d   = DONE;
        end else if (flush) begin
          disc_target_d = flush_target;
          state_d       = DISCARD;
        end
      end
      DISCARD: begin
        if (mem_ready) begin
          pc_d    = flush ? flush_target : disc_target_q;
          state_d = IDLE;
        end else if (flush) begin
          disc_target_d = flush_target;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      mem_addr_q    <= '0;
      disc_target_q <= '0;
      if_pc_q       <= '0;
      if_npc_q      <= '0;
      if_pred_q     <= '0;
      if_inst_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      disc_target_q <= disc_target_d;
      if_pc_q       <= if_pc_d;
      if_npc_q      <= if_npc_d;
      if_pred_q     <= if_pred_d;
      if_inst_q     <= if_inst_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: a memory responder with per-address latency, a
// scoreboard of expected fetch results, and directed scenarios for redirects,
// stalls, PC wrap, BTB prediction and asynchronous reset.

`ifndef AddrLen
`define AddrLen 32
`endif
`ifndef InstLen
`define InstLen 32
`endif
`ifndef PipelineDepth
`define PipelineDepth 5
`endif
`ifndef FlushInst
`define FlushInst 32'h0000_0013
`endif

module tb_if_stage;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] pred;
    bit          dropped;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic [`PipelineDepth-1:0] stall = '0;
  logic                      flush = 1'b0;
  logic [31:0]               flush_target = '0;
  logic                      mem_req;
  logic [31:0]               mem_addr;
  logic                      mem_ready = 1'b0;
  logic [31:0]               mem_rdata = '0;
  logic                      stall_req;
  logic [31:0]               if_pc;
  logic [31:0]               if_npc;
  logic [31:0]               if_prediction;
  logic [31:0]               if_inst;
  logic                      btb_we = 1'b0;
  logic [31:0]               btb_wpc = '0;
  logic [31:0]               btb_wtarget = '0;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          doneCount = 0;
  int          waitCnt = 0;
  bit          hsFlag = 1'b0;
  logic [31:0] hsAddr = '0;
  bit          holdReady = 1'b0;
  bit          forceReady = 1'b0;
  int          stallCycles;
  logic [31:0] btbPred;

  if_stage #(.BTB_ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_target(flush_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_req(stall_req), .if_pc(if_pc), .if_npc(if_npc), .if_prediction(if_prediction),
    .if_inst(if_inst), .btb_we(btb_we), .btb_wpc(btb_wpc), .btb_wtarget(btb_wtarget)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] instFor(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic int latFor(input logic [31:0] a);
    if (a == 32'h10 || a == 32'h14) return 4;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic [31:0] tgt, input logic s0);
    flush        = f;
    flush_target = tgt;
    stall[0]     = s0;
  endtask

  task automatic expectFetch(input logic [31:0] a, input logic [31:0] npc, input logic [31:0] pred);
    exp_t e;
    e.addr = a; e.inst = instFor(a); e.pc = a; e.npc = npc; e.pred = pred; e.dropped = 1'b0;
    expQ.push_back(e);
  endtask

  task automatic expectDrop(input logic [31:0] a);
    exp_t e;
    e.addr = a; e.inst = instFor(a); e.pc = '0; e.npc = '0; e.pred = '0; e.dropped = 1'b1;
    expQ.push_back(e);
  endtask

  task automatic waitFetches(input int target);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (doneCount >= target) return;
    end
    checkOutput("fetchTimeout", 32'(doneCount), 32'(target));
  endtask

  task automatic waitForReq();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) return;
    end
    checkOutput("reqTimeout", 32'(mem_req), 32'd1);
  endtask

  // Memory responder: answers each request after its address-dependent latency
  always @(negedge clk) begin
    if (forceReady) begin
      mem_ready = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
    end else if (rst && mem_req && !holdReady) begin
      if (waitCnt >= latFor(mem_addr)) begin
        mem_ready = 1'b1;
        mem_rdata = instFor(mem_addr);
        hsAddr    = mem_addr;
        hsFlag    = 1'b1;
      end else begin
        mem_ready = 1'b0;
        waitCnt++;
      end
    end else begin
      mem_ready = 1'b0;
      waitCnt   = 0;
    end
  end

  // Monitor: after every completed handshake, compare against the scoreboard head
  always begin
    @(posedge clk);
    #1;
    if (hsFlag) begin
      hsFlag = 1'b0;
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpectedFetch", hsAddr, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("fetchAddr", hsAddr, e.addr);
        if (e.dropped) begin
          checks++;
          if (if_inst === e.inst) begin
            errors++;
            $display("[TB] FAIL dropData: got %h expected not %h at %0t", if_inst, e.inst, $time);
          end
        end else begin
          checkOutput("ifInst", if_inst, e.inst);
          checkOutput("ifPc", if_pc, e.pc);
          checkOutput("ifNpc", if_npc, e.npc);
          checkOutput("ifPred", if_prediction, e.pred);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
`ifdef BTB_EN
    btbPred = 32'h100;
`else
    btbPred = 32'h44;
`endif
    // Reset state
    applyStimulus(1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("rstMemReq", 32'(mem_req), 32'd0);
    checkOutput("rstStallReq", 32'(stall_req), 32'd0);
    checkOutput("rstMemAddr", mem_addr, 32'h0);
    checkOutput("rstIfPc", if_pc, 32'h0);
    checkOutput("rstIfNpc", if_npc, 32'h0);
    checkOutput("rstIfInst", if_inst, 32'h0);
    checkOutput("rstIfPred", if_prediction, 32'h0);

    // Sequential fetches 0, 4, 8
    expectFetch(32'h0, 32'h4, 32'h4);
    expectFetch(32'h4, 32'h8, 32'h8);
    expectFetch(32'h8, 32'hC, 32'hC);
    @(negedge clk);
    rst = 1'b1;
    waitFetches(3);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Hold in DONE for four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("holdIfPc", if_pc, 32'h8);
      checkOutput("holdIfInst", if_inst, instFor(32'h8));
      checkOutput("holdMemReq", 32'(mem_req), 32'd0);
    end

    // Fetch 0xC, then a slow fetch at 0x10
    expectFetch(32'hC, 32'h10, 32'h10);
    expectFetch(32'h10, 32'h14, 32'h14);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(4);
    stallCycles = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (doneCount >= 5) break;
      if (stall_req) begin
        stallCycles++;
        checkOutput("slowAddrStable", mem_addr, 32'h10);
      end
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("slowStallCycles", 32'(stallCycles), 32'd5);

    // Flush two cycles into WAIT at 0x14; stale data dropped
    expectDrop(32'h14);
    expectFetch(32'h200, 32'h204, 32'h204);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitForReq();
    @(negedge clk);
    applyStimulus(1'b1, 32'h200, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(7);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Flush coincident with mem_ready at 0x204
    expectDrop(32'h204);
    expectFetch(32'h300, 32'h304, 32'h304);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitForReq();
    @(negedge clk);
    applyStimulus(1'b1, 32'h300, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(9);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Flush while stalled in DONE inserts a bubble
    @(negedge clk);
    applyStimulus(1'b1, 32'h400, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("bubbleInst", if_inst, `FlushInst);
    checkOutput("bubblePc", if_pc, 32'h0);
    checkOutput("bubblePred", if_prediction, 32'h0);
    expectFetch(32'h400, 32'h404, 32'h404);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(10);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // BTB update for 0x40 -> 0x100, then fetch 0x40
    @(negedge clk);
    btb_we = 1'b1; btb_wpc = 32'h40; btb_wtarget = 32'h100;
    @(negedge clk);
    btb_we = 1'b0;
    applyStimulus(1'b1, 32'h40, 1'b1);
    @(negedge clk);
    expectFetch(32'h40, 32'h44, btbPred);
    expectFetch(btbPred, btbPred + 32'h4, btbPred + 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(12);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space
    @(negedge clk);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    expectFetch(32'hFFFF_FFFC, 32'h0, 32'h0);
    expectFetch(32'h0, 32'h4, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitFetches(14);
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Asynchronous reset in the middle of WAIT
    holdReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0);
    waitForReq();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("midRstMemReq", 32'(mem_req), 32'd0);
    checkOutput("midRstStallReq", 32'(stall_req), 32'd0);
    checkOutput("midRstMemAddr", mem_addr, 32'h0);
    checkOutput("midRstIfPc", if_pc, 32'h0);
    checkOutput("midRstIfNpc", if_npc, 32'h0);
    checkOutput("midRstIfInst", if_inst, 32'h0);
    checkOutput("midRstIfPred", if_prediction, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    forceReady = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    forceReady = 1'b0;
    holdReady  = 1'b0;
    @(negedge clk);
    checkOutput("lateReadyInst", if_inst, 32'h0);
    checkOutput("lateReadyPc", if_pc, 32'h0);
    checkOutput("lateReadyMemReq", 32'(mem_req), 32'd0);
    checkOutput("lateReadyStallReq", 32'(stall_req), 32'd0);
    checkOutput("lateReadyFetches", 32'(doneCount), 32'd14);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
